// File: rtl/l2_port_arbiter.sv
// Arbitrates the unified L2 request port between the IL1 refill path and the
// DL1 miss/writeback path, and sequences DL1 flushes so no transfer overlaps one.
module l2_port_arbiter #(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 128,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic [DATA_BITS-1:0] i_dout,
    output logic                 i_ready,
    input  logic                 d_en,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [DATA_BITS-1:0] d_din,
    output logic [DATA_BITS-1:0] d_dout,
    output logic                 d_ready,
    output logic                 d_accepting,
    input  logic                 flush_req,
    output logic                 flushed,
    output logic                 m_en,
    output logic                 m_we,
    output logic [ADDR_BITS-1:0] m_addr,
    output logic [DATA_BITS-1:0] m_din,
    input  logic [DATA_BITS-1:0] m_dout,
    input  logic                 m_ready,
    output logic [1:0]           owner
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP, FLUSH} arbStateT;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arbStateT             state, stateNext;
    logic [3:0]           starveCnt, starveNext;
    logic                 mEnNext, mWeNext, iReadyNext, dReadyNext, flushedNext;
    logic [ADDR_BITS-1:0] mAddrNext;
    logic [DATA_BITS-1:0] mDinNext, iDoutNext, dDoutNext;
    logic [1:0]           ownerNext;

    // Combinational view of the state register so DL1 knows whether this edge samples it.
    assign d_accepting = (state == IDLE) && !flush_req;

    always_comb begin
        stateNext   = state;
        starveNext  = starveCnt;
        mEnNext     = m_en;
        mWeNext     = m_we;
        mAddrNext   = m_addr;
        mDinNext    = m_din;
        iDoutNext   = i_dout;
        dDoutNext   = d_dout;
        iReadyNext  = 1'b0;
        dReadyNext  = 1'b0;
        flushedNext = 1'b0;
        ownerNext   = owner;
        case (state)
            IDLE: begin
                ownerNext = 2'b00;
                if (flush_req) begin
                    stateNext = FLUSH;
                    ownerNext = 2'b11;
                end else if (i_en && (!d_en || starveCnt == STARVE_MAX)) begin
                    stateNext  = BUSY_I;
                    starveNext = 4'd0;
                    mEnNext    = 1'b1;
                    mWeNext    = 1'b0;
                    mAddrNext  = i_addr;
                    ownerNext  = 2'b01;
                end else if (d_en) begin
                    // Only a contested win by DL1 counts toward instruction starvation.
                    if (i_en) starveNext = starveCnt + 4'd1;
                    stateNext = BUSY_D;
                    mEnNext   = 1'b1;
                    mWeNext   = d_we;
                    mAddrNext = d_addr;
                    mDinNext  = d_din;
                    ownerNext = 2'b10;
                end
            end
            BUSY_I: begin
                if (m_ready) begin
                    stateNext  = RESP;
                    mEnNext    = 1'b0;
                    iDoutNext  = m_dout;
                    iReadyNext = 1'b1;
                end
            end
            BUSY_D: begin
                if (m_ready) begin
                    stateNext  = RESP;
                    mEnNext    = 1'b0;
                    dDoutNext  = m_dout;
                    dReadyNext = 1'b1;
                end
            end
            RESP: begin
                stateNext = IDLE;
                ownerNext = 2'b00;
            end
            FLUSH: begin
                if (flush_req) begin
                    flushedNext = 1'b1;
                end else begin
                    stateNext = IDLE;
                    ownerNext = 2'b00;
                end
            end
            default: begin
                stateNext = IDLE;
                ownerNext = 2'b00;
                mEnNext   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            starveCnt <= 4'd0;
            m_en      <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_din     <= '0;
            i_dout    <= '0;
            d_dout    <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            flushed   <= 1'b0;
            owner     <= 2'b00;
        end else begin
            state     <= stateNext;
            starveCnt <= starveNext;
            m_en      <= mEnNext;
            m_we      <= mWeNext;
            m_addr    <= mAddrNext;
            m_din     <= mDinNext;
            i_dout    <= iDoutNext;
            d_dout    <= dDoutNext;
            i_ready   <= iReadyNext;
            d_ready   <= dReadyNext;
            flushed   <= flushedNext;
            owner     <= ownerNext;
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed and randomized bench for l2_port_arbiter; grants are predicted from
// the arbitration rules (priority plus starvation count) and data from a scoreboard.
module tb_l2_port_arbiter;

    localparam int AB = 32;
    localparam int DB = 128;
    localparam int SL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_en, d_en, d_we, flush_req, m_ready;
    logic [AB-1:0] i_addr, d_addr;
    logic [DB-1:0] d_din, m_dout;
    logic [DB-1:0] i_dout, d_dout, m_din;
    logic          i_ready, d_ready, d_accepting, flushed, m_en, m_we;
    logic [AB-1:0] m_addr;
    logic [1:0]    owner;

    int compared   = 0;
    int mismatched = 0;
    int modelLosses = 0;

    l2_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .i_en(i_en), .i_addr(i_addr), .i_dout(i_dout), .i_ready(i_ready),
        .d_en(d_en), .d_we(d_we), .d_addr(d_addr), .d_din(d_din),
        .d_dout(d_dout), .d_ready(d_ready), .d_accepting(d_accepting),
        .flush_req(flush_req), .flushed(flushed),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_din(m_din),
        .m_dout(m_dout), .m_ready(m_ready), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit ie, input logic [AB-1:0] ia,
                                 input bit de, input bit dw, input logic [AB-1:0] da,
                                 input logic [DB-1:0] dd);
        i_en = ie; i_addr = ia;
        d_en = de; d_we = dw; d_addr = da; d_din = dd;
    endtask

    function automatic logic [DB-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at an IDLE negedge with requests already driven; runs one full transaction.
    task automatic serviceOne(input int lat, input logic [DB-1:0] rdata, output bit grantedD);
        bit            expD;
        bit            expWe;
        logic [AB-1:0] expAddr;
        logic [DB-1:0] expDin;
        if (i_en && d_en) begin
            if (modelLosses == SL) begin expD = 1'b0; modelLosses = 0; end
            else begin expD = 1'b1; modelLosses++; end
        end else if (d_en) begin
            expD = 1'b1;
        end else begin
            expD = 1'b0;
            modelLosses = 0;
        end
        expAddr = expD ? d_addr : i_addr;
        expWe   = expD ? d_we : 1'b0;
        expDin  = d_din;
        tick();
        checkOutput("grant_m_en", m_en, 1);
        checkOutput("grant_owner", owner, expD ? 2 : 1);
        checkOutput("grant_m_addr", m_addr, expAddr);
        checkOutput("grant_m_we", m_we, expWe);
        if (expWe) checkOutput("grant_m_din", m_din, expDin);
        grantedD = (owner == 2'b10);
        for (int c = 1; c < lat; c++) begin
            tick();
            checkOutput("hold_m_en", m_en, 1);
            checkOutput("hold_m_addr", m_addr, expAddr);
            if (expWe) checkOutput("hold_m_din", m_din, expDin);
        end
        m_ready = 1'b1;
        m_dout  = rdata;
        tick();
        m_ready = 1'b0;
        m_dout  = rand128();
        checkOutput("resp_m_en", m_en, 0);
        checkOutput("resp_i_ready", i_ready, !expD);
        checkOutput("resp_d_ready", d_ready, expD);
        if (!expD) checkOutput("resp_i_dout", i_dout, rdata);
        else if (!expWe) checkOutput("resp_d_dout", d_dout, rdata);
        tick();
        checkOutput("idle_i_ready", i_ready, 0);
        checkOutput("idle_d_ready", d_ready, 0);
        checkOutput("idle_owner", owner, 0);
        checkOutput("idle_accepting", d_accepting, 1);
        if (expD) d_en = 1'b0;
        else i_en = 1'b0;
    endtask

    initial begin
        bit gotD;
        bit expSeq[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b0;
        flush_req = 1'b0;
        m_ready = 1'b0;
        m_dout = '0;
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick();
        checkOutput("rst_m_en", m_en, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_m_addr", m_addr, 0);
        checkOutput("rst_i_dout", i_dout, 0);
        checkOutput("rst_flushed", flushed, 0);
        checkOutput("rst_accepting", d_accepting, 1);
        reset = 1'b1;
        tick();

        $display("[TB] single instruction read");
        applyStimulus(1, 32'h100, 0, 0, '0, '0);
        serviceOne(4, 128'hAAAA, gotD);

        $display("[TB] data write");
        applyStimulus(0, '0, 1, 1, 32'h2000, 128'h1234);
        serviceOne(3, rand128(), gotD);

        $display("[TB] contention and starvation");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 32'h4000 + 32'(k), 1, 0, 32'h8000 + 32'(k), rand128());
            serviceOne(2, rand128(), gotD);
            checkOutput("starve_seq", gotD, expSeq[k]);
        end

        $display("[TB] flush during data transfer");
        applyStimulus(0, '0, 1, 0, 32'h3000, '0);
        tick();
        checkOutput("fl_busy_owner", owner, 2);
        flush_req = 1'b1;
        i_en = 1'b1;
        i_addr = 32'h400;
        tick();
        m_ready = 1'b1;
        m_dout = 128'h5555;
        tick();
        m_ready = 1'b0;
        checkOutput("fl_d_ready", d_ready, 1);
        checkOutput("fl_d_dout", d_dout, 128'h5555);
        d_en = 1'b0;
        tick();
        checkOutput("fl_idle_accepting", d_accepting, 0);
        tick();
        checkOutput("fl_owner", owner, 3);
        checkOutput("fl_m_en", m_en, 0);
        checkOutput("fl_flushed_entry", flushed, 0);
        tick();
        checkOutput("fl_flushed", flushed, 1);
        checkOutput("fl_accepting", d_accepting, 0);
        checkOutput("fl_m_en_hold", m_en, 0);
        flush_req = 1'b0;
        tick();
        checkOutput("fl_release", flushed, 0);
        checkOutput("fl_release_owner", owner, 0);
        serviceOne(2, rand128(), gotD);
        checkOutput("fl_then_i", gotD, 0);

        $display("[TB] stray m_ready in idle");
        m_ready = 1'b1;
        m_dout = rand128();
        tick();
        m_ready = 1'b0;
        checkOutput("stray_i_ready", i_ready, 0);
        checkOutput("stray_d_ready", d_ready, 0);
        checkOutput("stray_owner", owner, 0);
        checkOutput("stray_m_en", m_en, 0);

        $display("[TB] async reset mid instruction transfer");
        applyStimulus(1, 32'h600, 0, 0, '0, '0);
        tick();
        checkOutput("ar_m_en_before", m_en, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("ar_m_en", m_en, 0);
        checkOutput("ar_owner", owner, 0);
        checkOutput("ar_i_ready", i_ready, 0);
        tick();
        reset = 1'b1;
        i_en = 1'b0;
        modelLosses = 0;
        m_ready = 1'b1;
        m_dout = rand128();
        tick();
        m_ready = 1'b0;
        checkOutput("ar_late_i_ready", i_ready, 0);
        checkOutput("ar_late_owner", owner, 0);
        tick();
        checkOutput("ar_late_i_ready2", i_ready, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            if (!i_en) begin
                i_en = 1'($urandom_range(0, 1));
                i_addr = $urandom();
            end
            if (!d_en) begin
                d_en = 1'($urandom_range(0, 1));
                d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom();
                d_din = rand128();
            end
            if (!i_en && !d_en) d_en = 1'b1;
            serviceOne(int'($urandom_range(1, 4)), rand128(), gotD);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
